fc_layer_sequencer: RTL

Hardware sequencer that runs a 1–3 layer fully-connected network through the single FC engine (fc_top / fc_module datapath) without per-phase CPU intervention. For each layer it loads the layer size configuration, pulses fc_start, steps COMMAND through feature-load, bias-load, calculate and output phases, and advances on the engine's status flags. It sits between the APB register block and the FC engine's control inputs, and replaces direct software driving of COMMAND.

---
 rtl/fc_layer_sequencer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/fc_layer_sequencer.sv
// Runs a 1-3 layer fully-connected network through one FC engine by stepping
// COMMAND through feature/bias/calc/output phases for each layer.
module fc_layer_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        seq_start,
  input  logic        seq_abort,
  input  logic [1:0]  num_layers,
  input  logic [47:0] cfg_in_words,
  input  logic [47:0] cfg_out_words,
  input  logic        F_writedone,
  input  logic        B_writedone,
  input  logic        cal_done,
  input  logic        fc_done,
  input  logic [31:0] max_index,
  output logic        fc_start,
  output logic [2:0]  COMMAND,
  output logic [31:0] num_input_words,
  output logic [31:0] num_output_words,
  output logic [1:0]  cur_layer,
  output logic        seq_busy,
  output logic        seq_done,
  output logic        seq_error,
  output logic [31:0] result_index
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_LOAD_F, S_LOAD_B, S_CALC, S_OUT, S_DONE, S_ERR
  } state_e;

  typedef enum logic [2:0] {
    CMD_IDLE = 3'd0,
    CMD_LOAD_F = 3'd1,
    CMD_LOAD_B = 3'd2,
    CMD_CALC = 3'd3,
    CMD_OUT = 3'd4
  } cmd_e;

  state_e      state_q, state_d;
  logic [1:0]  layers_q, layers_d;
  logic [1:0]  layer_q, layer_d;
  logic        err_q, err_d;
  logic [31:0] result_q, result_d;
  logic [31:0] in_q, in_d;
  logic [31:0] out_q, out_d;
  logic [31:0] wd_q, wd_d;
  logic        fc_start_q, fc_start_d;
  cmd_e        cmd_q, cmd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        in_wait;
  logic        settled;
  logic        timed_out;

  function automatic logic [15:0] pick(input logic [47:0] v, input logic [1:0] idx);
    logic [15:0] r;
    case (idx)
      2'd0:    r = v[15:0];
      2'd1:    r = v[31:16];
      2'd2:    r = v[47:32];
      default: r = '0;
    endcase
    return r;
  endfunction

  assign in_wait   = (state_q == S_LOAD_F) || (state_q == S_LOAD_B) ||
                     (state_q == S_CALC)   || (state_q == S_OUT);
  // The watchdog doubles as the settle marker: zero only in a phase's first cycle.
  assign settled   = (wd_q != '0);
  assign timed_out = (wd_q >= (TIMEOUT_CYCLES - 32'd1));

  always_comb begin
    state_d  = state_q;
    layers_d = layers_q;
    layer_d  = layer_q;
    err_d    = err_q;
    result_d = result_q;
    in_d     = in_q;
    out_d    = out_q;

    if (seq_abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_ERR: begin
          if (seq_start) begin
            if (num_layers != 2'd0) begin
              layers_d = num_layers;
              layer_d  = '0;
              err_d    = 1'b0;
              state_d  = S_SETUP;
            end else begin
              state_d = S_ERR;
            end
          end
        end
        S_SETUP: state_d = S_LOAD_F;
        S_LOAD_F: begin
          if (settled && F_writedone) state_d = S_LOAD_B;
          else if (timed_out)         state_d = S_ERR;
        end
        S_LOAD_B: begin
          if (settled && B_writedone) state_d = S_CALC;
          else if (timed_out)         state_d = S_ERR;
        end
        S_CALC: begin
          if (settled && cal_done) state_d = S_OUT;
          else if (timed_out)      state_d = S_ERR;
        end
        S_OUT: begin
          if (settled && fc_done) begin
            if (layer_q < (layers_q - 2'd1)) begin
              layer_d = layer_q + 2'd1;
              state_d = S_SETUP;
            end else begin
              result_d = max_index;
              state_d  = S_DONE;
            end
          end else if (timed_out) begin
            state_d = S_ERR;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    if (state_d == S_ERR) err_d = 1'b1;

    if (state_d == S_SETUP) begin
      in_d  = {16'd0, pick(cfg_in_words, layer_d)};
      out_d = {16'd0, pick(cfg_out_words, layer_d)};
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    fc_start_d = (state_d == S_SETUP);
    busy_d     = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERR));
    done_d     = (state_d == S_DONE);
    case (state_d)
      S_LOAD_F: cmd_d = CMD_LOAD_F;
      S_LOAD_B: cmd_d = CMD_LOAD_B;
      S_CALC:   cmd_d = CMD_CALC;
      S_OUT:    cmd_d = CMD_OUT;
      default:  cmd_d = CMD_IDLE;
    endcase

    if (state_d != state_q) wd_d = '0;
    else if (in_wait)       wd_d = wd_q + 32'd1;
    else                    wd_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      layers_q   <= '0;
      layer_q    <= '0;
      err_q      <= 1'b0;
      result_q   <= '0;
      in_q       <= '0;
      out_q      <= '0;
      wd_q       <= '0;
      fc_start_q <= 1'b0;
      cmd_q      <= CMD_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      layers_q   <= layers_d;
      layer_q    <= layer_d;
      err_q      <= err_d;
      result_q   <= result_d;
      in_q       <= in_d;
      out_q      <= out_d;
      wd_q       <= wd_d;
      fc_start_q <= fc_start_d;
      cmd_q      <= cmd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign fc_start         = fc_start_q;
  assign COMMAND          = cmd_q;
  assign num_input_words  = in_q;
  assign num_output_words = out_q;
  assign cur_layer        = layer_q;
  assign seq_busy         = busy_q;
  assign seq_done         = done_q;
  assign seq_error        = err_q;
  assign result_index     = result_q;

endmodule
